// File: rtl/fifo_rd_serializer_pkg.sv
// Shared types for the FIFO pop-side serializer.
// Optional out_last_o port is enabled by defining FIFO_RD_LAST_EN.
package fifo_rd_pkg;
  typedef enum logic {IDLE, SEND} fifo_rd_state_t;
endpackage

// File: rtl/fifo_rd_serializer_if.sv
// FIFO pop port plus narrow valid/ready beat stream for fifo_rd_serializer.
// out_last_o exists only when FIFO_RD_LAST_EN is defined.
interface fifo_rd_serializer_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 4
);
  logic              empty_i;
  logic [DATA_W-1:0] pop_data_i;
  logic              pop_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [OUT_W-1:0]  out_data_o;
  logic              busy_o;
`ifdef FIFO_RD_LAST_EN
  logic              out_last_o;

  modport master (input empty_i, pop_data_i, out_ready_i,
                  output pop_o, out_valid_o, out_data_o, busy_o, out_last_o);
  modport slave  (output empty_i, pop_data_i, out_ready_i,
                  input pop_o, out_valid_o, out_data_o, busy_o, out_last_o);
`else
  modport master (input empty_i, pop_data_i, out_ready_i,
                  output pop_o, out_valid_o, out_data_o, busy_o);
  modport slave  (output empty_i, pop_data_i, out_ready_i,
                  input pop_o, out_valid_o, out_data_o, busy_o);
`endif
endinterface

// File: rtl/fifo_rd_serializer.sv
// Pops DATA_W words from a fall-through FIFO and streams them as OUT_W beats, LSB first.
// Define FIFO_RD_LAST_EN to drive out_last_o on the final beat of each word.
module fifo_rd_serializer
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  fifo_rd_serializer_if.master bus
);
  localparam int RATIO = DATA_W / OUT_W;
  localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

  if (DATA_W % OUT_W != 0) begin : g_bad_ratio
    $fatal(1, "fifo_rd_serializer: DATA_W must be a multiple of OUT_W");
  end

  fifo_rd_state_t    r_state;
  logic [BW-1:0]     r_beat;
  logic [DATA_W-1:0] r_word;

  logic w_hs, w_last, w_pop;

  assign w_hs   = bus.out_valid_o && bus.out_ready_i;
  assign w_last = (r_beat == LAST_BEAT);
  // Reload on the last-beat handshake keeps the stream bubble-free across words.
  assign w_pop  = !bus.empty_i && ((r_state == IDLE) || (w_hs && w_last));

  assign bus.pop_o       = w_pop;
  assign bus.out_valid_o = (r_state == SEND);
  assign bus.busy_o      = (r_state == SEND);
  assign bus.out_data_o  = r_word[OUT_W-1:0];
`ifdef FIFO_RD_LAST_EN
  assign bus.out_last_o  = (r_state == SEND) && w_last;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_word  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_word  <= bus.pop_data_i;
            r_beat  <= '0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_hs) begin
            if (w_last) begin
              r_beat <= '0;
              if (w_pop) begin
                r_word <= bus.pop_data_i;
              end else begin
                r_word  <= r_word >> OUT_W;
                r_state <= IDLE;
              end
            end else begin
              r_word <= r_word >> OUT_W;
              r_beat <= r_beat + BW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
